bus_mailbox: RTL and testbench

Memory-mapped responder on the CPU external bus (16-bit address, 16-bit data, active-low RDN, per-byte active-low WRN0/WRN1). Provides two DEPTH-entry FIFOs between the CPU and a host-side stream interface: RX (host to CPU) and TX (CPU to host). Raises an interrupt request intended for the core's INT0 or INT1 input. Zero-wait-state reads; side effects are applied at strobe boundaries.

---
 rtl/bus_mailbox_pkg.sv | 34 +++
 rtl/mailbox_fifo.sv | 59 +++++
 rtl/bus_mailbox.sv | 211 +++++++++++++++++++++
 tb/tb_bus_mailbox.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_mailbox_pkg.sv
// bus_mailbox_pkg
//   Shared constants for the bus mailbox: default register window base,
//   register index encoding, and STATUS / CONTROL bit positions.
package bus_mailbox_pkg;

    localparam logic [15:0] BASE_ADDR_DEFAULT = 16'hFF00;

    // Register index, taken from ADDR[2:1]
    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CONTROL = 2'd2,
        REG_LEVEL   = 2'd3
    } reg_idx_e;

    // STATUS bit positions
    localparam int unsigned ST_RX_EMPTY = 0;
    localparam int unsigned ST_RX_FULL  = 1;
    localparam int unsigned ST_TX_EMPTY = 2;
    localparam int unsigned ST_TX_FULL  = 3;
    localparam int unsigned ST_RX_OVF   = 5;
    localparam int unsigned ST_RX_UNF   = 6;
    localparam int unsigned ST_TX_OVF   = 7;

    // CONTROL bit positions
    localparam int unsigned CT_RX_IE      = 0;
    localparam int unsigned CT_TX_IE      = 1;
    localparam int unsigned CT_CLR_RX_OVF = 2;
    localparam int unsigned CT_CLR_RX_UNF = 3;
    localparam int unsigned CT_CLR_TX_OVF = 4;
    localparam int unsigned CT_WM_LSB     = 8;
    localparam int unsigned CT_WM_MSB     = 11;

endpackage

// File: rtl/mailbox_fifo.sv
// mailbox_fifo
//   Synchronous 16-bit FIFO with DEPTH entries (power of two, >= 2).
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write request and data (ignored when full)
//   pop           read request (ignored when empty)
//   full, empty   occupancy flags
//   level         number of stored entries (DEPTH_LOG2+1 bits)
//   head          oldest entry, 0 when empty
module mailbox_fifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [15:0]           din,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           head
);

    logic [15:0]         mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_mailbox.sv
// bus_mailbox
//   Memory-mapped CPU bus responder with an RX FIFO (host -> CPU) and a
//   TX FIFO (CPU -> host), sticky error flags and a registered IRQ.
//   Registers (index ADDR[2:1]): 0 DATA, 1 STATUS, 2 CONTROL, 3 LEVEL.
//   Optional feature macro: BUS_MAILBOX_WATERMARK_EN adds a 4-bit RX
//   watermark in CONTROL[11:8] that gates the RX interrupt condition.
// Ports:
//   CLK, RESET                      clock, asynchronous active-high reset
//   ADDR, DIN, RDN, WRN0, WRN1      CPU bus (active-low strobes)
//   DOUT, DOUT_OEN                  combinational read data / drive enable
//   IRQ                             registered interrupt request
//   HOST_RX_DATA/VALID/READY        host stream into RX FIFO
//   HOST_TX_DATA/VALID/READY        host stream out of TX FIFO
module bus_mailbox
    import bus_mailbox_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] ADDR,
    input  logic [15:0] DIN,
    input  logic        RDN,
    input  logic        WRN0,
    input  logic        WRN1,
    output logic [15:0] DOUT,
    output logic        DOUT_OEN,
    output logic        IRQ,
    input  logic [15:0] HOST_RX_DATA,
    input  logic        HOST_RX_VALID,
    output logic        HOST_RX_READY,
    output logic [15:0] HOST_TX_DATA,
    output logic        HOST_TX_VALID,
    input  logic        HOST_TX_READY
);

    logic                sel;
    reg_idx_e            idx;
    logic                rd_active;
    logic                wr_any;
    logic                wr_fire;
    logic                wr_idle_q;
    logic                rd_pend;

    logic                rx_full, rx_empty, tx_full, tx_empty;
    logic [DEPTH_LOG2:0] rx_level, tx_level;
    logic [7:0]          rx_lvl8, tx_lvl8;
    logic [15:0]         rx_head, tx_head;
    logic                rx_push, rx_pop, tx_push, tx_pop;
    logic [15:0]         tx_word;

    logic                rx_ie, tx_ie;
    logic                rx_ovf, rx_unf, tx_ovf;
    logic                rx_ovf_set, rx_unf_set, tx_ovf_set;
    logic                ctrl_lo_wr, ctrl_hi_wr;
    logic                rx_irq_cond;
    logic [3:0]          wm;

    logic                unused_addr0;
    assign unused_addr0 = ADDR[0];

    // ---------------- decode ----------------
    assign sel       = (ADDR[15:3] == BASE_ADDR[15:3]);
    assign idx       = reg_idx_e'(ADDR[2:1]);
    assign rd_active = sel & ~RDN;
    assign wr_any    = ~WRN0 | ~WRN1;

    // wr_idle_q records that the strobe was inactive on the previous cycle.
    // It resets to 0 so a strobe already low at reset release never fires.
    assign wr_fire    = wr_any & sel & wr_idle_q;
    assign ctrl_lo_wr = wr_fire & (idx == REG_CONTROL) & ~WRN0;
    assign ctrl_hi_wr = wr_fire & (idx == REG_CONTROL) & ~WRN1;

    // ---------------- FIFO control ----------------
    assign rx_push    = HOST_RX_VALID & ~rx_full;
    assign rx_pop     = rd_pend & RDN;
    assign tx_word    = {WRN1 ? 8'h00 : DIN[15:8], WRN0 ? 8'h00 : DIN[7:0]};
    assign tx_push    = wr_fire & (idx == REG_DATA) & ~tx_full;
    assign tx_pop     = HOST_TX_VALID & HOST_TX_READY;

    assign rx_ovf_set = HOST_RX_VALID & rx_full;
    assign rx_unf_set = rd_active & (idx == REG_DATA) & rx_empty;
    assign tx_ovf_set = wr_fire & (idx == REG_DATA) & tx_full;

    mailbox_fifo #(
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (HOST_RX_DATA),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level),
        .head  (rx_head)
    );

    mailbox_fifo #(
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (tx_word),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level),
        .head  (tx_head)
    );

    assign rx_lvl8       = 8'(rx_level);
    assign tx_lvl8       = 8'(tx_level);
    assign HOST_RX_READY = ~rx_full;
    assign HOST_TX_VALID = ~tx_empty;
    assign HOST_TX_DATA  = tx_head;

    // ---------------- watermark ----------------
`ifdef BUS_MAILBOX_WATERMARK_EN
    logic [7:0] wm_eff;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wm <= '0;
        end else if (ctrl_hi_wr) begin
            wm <= DIN[CT_WM_MSB:CT_WM_LSB];
        end
    end

    // A watermark of 0 behaves like 1 so the IRQ never fires on an empty FIFO
    assign wm_eff      = (wm == 4'd0) ? 8'd1 : {4'b0, wm};
    assign rx_irq_cond = (rx_lvl8 >= wm_eff);
`else
    logic unused_ctrl_hi;
    assign unused_ctrl_hi = ctrl_hi_wr;
    assign wm             = '0;
    assign rx_irq_cond    = ~rx_empty;
`endif

    // ---------------- registers ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_idle_q <= 1'b0;
            rd_pend   <= 1'b0;
            rx_ie     <= 1'b0;
            tx_ie     <= 1'b0;
            rx_ovf    <= 1'b0;
            rx_unf    <= 1'b0;
            tx_ovf    <= 1'b0;
            IRQ       <= 1'b0;
        end else begin
            wr_idle_q <= ~wr_any;

            // One pop per DATA strobe: armed while RDN low, popped when it rises
            if (rd_pend) begin
                if (RDN) begin
                    rd_pend <= 1'b0;
                end
            end else if (rd_active && (idx == REG_DATA) && !rx_empty) begin
                rd_pend <= 1'b1;
            end

            if (ctrl_lo_wr) begin
                rx_ie <= DIN[CT_RX_IE];
                tx_ie <= DIN[CT_TX_IE];
            end

            // Sticky set takes priority over a same-cycle clear
            if (rx_ovf_set) begin
                rx_ovf <= 1'b1;
            end else if (ctrl_lo_wr && DIN[CT_CLR_RX_OVF]) begin
                rx_ovf <= 1'b0;
            end
            if (rx_unf_set) begin
                rx_unf <= 1'b1;
            end else if (ctrl_lo_wr && DIN[CT_CLR_RX_UNF]) begin
                rx_unf <= 1'b0;
            end
            if (tx_ovf_set) begin
                tx_ovf <= 1'b1;
            end else if (ctrl_lo_wr && DIN[CT_CLR_TX_OVF]) begin
                tx_ovf <= 1'b0;
            end

            IRQ <= (rx_ie & rx_irq_cond) | (tx_ie & tx_empty);
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        DOUT     = '0;
        DOUT_OEN = 1'b1;
        if (rd_active) begin
            DOUT_OEN = 1'b0;
            case (idx)
                REG_DATA:    DOUT = rx_head;
                REG_STATUS:  DOUT = {8'b0, tx_ovf, rx_unf, rx_ovf, 1'b0,
                                     tx_full, tx_empty, rx_full, rx_empty};
                REG_CONTROL: DOUT = {4'b0, wm, 6'b0, tx_ie, rx_ie};
                REG_LEVEL:   DOUT = {tx_lvl8, rx_lvl8};
                default:     DOUT = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mailbox.sv
module tb_bus_mailbox;

    localparam int unsigned DEPTH = 8;
    localparam logic [15:0] A_DATA = 16'hFF00;
    localparam logic [15:0] A_STAT = 16'hFF02;
    localparam logic [15:0] A_CTRL = 16'hFF04;
    localparam logic [15:0] A_LVL  = 16'hFF06;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] ADDR;
    logic [15:0] DIN;
    logic        RDN, WRN0, WRN1;
    logic [15:0] DOUT;
    logic        DOUT_OEN;
    logic        IRQ;
    logic [15:0] HOST_RX_DATA;
    logic        HOST_RX_VALID;
    logic        HOST_RX_READY;
    logic [15:0] HOST_TX_DATA;
    logic        HOST_TX_VALID;
    logic        HOST_TX_READY;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Scoreboard queues and reference flags
    logic [15:0] rx_q[$];
    logic [15:0] tx_q[$];
    logic        m_rx_ovf, m_rx_unf, m_tx_ovf;

    always #5 CLK = ~CLK;

    bus_mailbox #(
        .BASE_ADDR  (16'hFF00),
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (3)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .ADDR          (ADDR),
        .DIN           (DIN),
        .RDN           (RDN),
        .WRN0          (WRN0),
        .WRN1          (WRN1),
        .DOUT          (DOUT),
        .DOUT_OEN      (DOUT_OEN),
        .IRQ           (IRQ),
        .HOST_RX_DATA  (HOST_RX_DATA),
        .HOST_RX_VALID (HOST_RX_VALID),
        .HOST_RX_READY (HOST_RX_READY),
        .HOST_TX_DATA  (HOST_TX_DATA),
        .HOST_TX_VALID (HOST_TX_VALID),
        .HOST_TX_READY (HOST_TX_READY)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_status();
        int unsigned rn = rx_q.size();
        int unsigned tn = tx_q.size();
        return {8'b0, m_tx_ovf, m_rx_unf, m_rx_ovf, 1'b0,
                tn == DEPTH, tn == 0, rn == DEPTH, rn == 0};
    endfunction

    function automatic logic [15:0] exp_level();
        return {8'(tx_q.size()), 8'(rx_q.size())};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic host_push(input logic [15:0] d);
        HOST_RX_DATA  = d;
        HOST_RX_VALID = 1'b1;
        if (rx_q.size() < DEPTH) rx_q.push_back(d);
        else m_rx_ovf = 1'b1;
        tick();
        HOST_RX_VALID = 1'b0;
    endtask

    // Read strobe held low for 'hold' cycles; optional host push on the release cycle
    task automatic cpu_read(input string tag, input logic [15:0] addr, input int unsigned hold,
                            input logic [15:0] exp, input logic push_rel, input logic [15:0] pd);
        ADDR = addr;
        RDN  = 1'b0;
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge CLK);
            check(tag, DOUT, exp);
            check({tag, "_oen"}, {15'b0, DOUT_OEN}, 16'd0);
            tick();
        end
        RDN = 1'b1;
        if (push_rel) begin
            HOST_RX_DATA  = pd;
            HOST_RX_VALID = 1'b1;
        end
        tick();
        HOST_RX_VALID = 1'b0;
    endtask

    task automatic data_read(input string tag, input int unsigned hold,
                             input logic push_rel, input logic [15:0] pd);
        logic [15:0] e;
        logic        can_push;
        can_push = rx_q.size() < DEPTH;
        if (rx_q.size() == 0) begin
            e = 16'h0000;
            m_rx_unf = 1'b1;
        end else begin
            e = rx_q[0];
        end
        cpu_read(tag, A_DATA, hold, e, push_rel, pd);
        if (rx_q.size() != 0) void'(rx_q.pop_front());
        if (push_rel) begin
            if (can_push) rx_q.push_back(pd);
            else m_rx_ovf = 1'b1;
        end
    endtask

    task automatic read_reg(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        cpu_read(tag, addr, 1, exp, 1'b0, 16'h0);
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [15:0] d,
                             input logic w0, input logic w1, input int unsigned hold);
        ADDR = addr;
        DIN  = d;
        WRN0 = w0;
        WRN1 = w1;
        for (int unsigned i = 0; i < hold; i++) tick();
        WRN0 = 1'b1;
        WRN1 = 1'b1;
        tick();
    endtask

    task automatic data_write(input logic [15:0] d, input logic w0, input logic w1,
                              input int unsigned hold);
        logic [15:0] word;
        word = {w1 ? 8'h00 : d[15:8], w0 ? 8'h00 : d[7:0]};
        if (tx_q.size() < DEPTH) tx_q.push_back(word);
        else m_tx_ovf = 1'b1;
        cpu_write(A_DATA, d, w0, w1, hold);
    endtask

    // Model the effect of a low-byte CONTROL write on the clear bits
    task automatic ctrl_write(input logic [15:0] d);
        if (d[2]) m_rx_ovf = 1'b0;
        if (d[3]) m_rx_unf = 1'b0;
        if (d[4]) m_tx_ovf = 1'b0;
        cpu_write(A_CTRL, d, 1'b0, 1'b0, 1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        rx_q.delete();
        tx_q.delete();
        m_rx_ovf = 1'b0;
        m_rx_unf = 1'b0;
        m_tx_ovf = 1'b0;
        tick();
    endtask

    initial begin
        ADDR = 16'h0000; DIN = 16'h0000;
        RDN = 1'b1; WRN0 = 1'b1; WRN1 = 1'b1;
        HOST_RX_DATA = 16'h0; HOST_RX_VALID = 1'b0; HOST_TX_READY = 1'b0;
        do_reset();

        // Reset state and idle bus
        @(negedge CLK);
        check("idle_oen", {15'b0, DOUT_OEN}, 16'd1);
        check("idle_dout", DOUT, 16'h0000);
        check("rst_rx_ready", {15'b0, HOST_RX_READY}, 16'd1);
        check("rst_irq", {15'b0, IRQ}, 16'd0);
        check("rst_tx_valid", {15'b0, HOST_TX_VALID}, 16'd0);
        read_reg("rst_status", A_STAT, 16'h0005);

        // Host pushes, long CPU read gives one pop
        host_push(16'h1234);
        host_push(16'hABCD);
        data_read("rd_long", 3, 1'b0, 16'h0);
        read_reg("lvl_after_long", A_LVL, 16'h0001);
        data_read("rd_second", 1, 1'b0, 16'h0);
        read_reg("lvl_empty", A_LVL, exp_level());

        // TX: byte write, then overflow
        data_write(16'h5AA5, 1'b0, 1'b1, 3);
        @(negedge CLK);
        check("tx_byte_data", HOST_TX_DATA, 16'h00A5);
        check("tx_valid", {15'b0, HOST_TX_VALID}, 16'd1);
        for (int unsigned i = 0; i < 8; i++) data_write(16'h1000 + 16'(i * 16'h0111), 1'b0, 1'b0, 1);
        read_reg("tx_ovf_status", A_STAT, exp_status());
        read_reg("tx_full_level", A_LVL, exp_level());
        HOST_TX_READY = 1'b1;
        for (int unsigned n = 0; n < 2 * DEPTH && tx_q.size() != 0; n++) begin
            @(negedge CLK);
            check("tx_drain_data", HOST_TX_DATA, tx_q[0]);
            check("tx_drain_valid", {15'b0, HOST_TX_VALID}, 16'd1);
            void'(tx_q.pop_front());
            tick();
        end
        HOST_TX_READY = 1'b0;
        check("tx_drained", {15'b0, HOST_TX_VALID}, 16'd0);
        ctrl_write(16'h0010);
        read_reg("tx_ovf_clr", A_STAT, exp_status());

        // CONTROL readback; TX_IE with empty TX raises IRQ
`ifdef BUS_MAILBOX_WATERMARK_EN
        cpu_write(A_CTRL, 16'h0F03, 1'b0, 1'b0, 1);
        read_reg("ctrl_rb", A_CTRL, 16'h0F03);
`else
        cpu_write(A_CTRL, 16'h0F03, 1'b0, 1'b0, 1);
        read_reg("ctrl_rb", A_CTRL, 16'h0003);
`endif
        check("tx_irq", {15'b0, IRQ}, 16'd1);
        cpu_write(A_CTRL, 16'h0000, 1'b0, 1'b0, 1);
        tick();
        check("irq_off", {15'b0, IRQ}, 16'd0);

        // RX interrupt timing and underflow
        ctrl_write(16'h0001);
        host_push(16'h4242);
        check("irq_push_0", {15'b0, IRQ}, 16'd0);
        tick();
        check("irq_push_1", {15'b0, IRQ}, 16'd1);
        data_read("rd_irq", 1, 1'b0, 16'h0);
        check("irq_after_pop_0", {15'b0, IRQ}, 16'd1);
        tick();
        check("irq_after_pop_1", {15'b0, IRQ}, 16'd0);
        data_read("rd_empty", 1, 1'b0, 16'h0);
        read_reg("unf_status", A_STAT, exp_status());
        ctrl_write(16'h0008);
        read_reg("unf_clr", A_STAT, exp_status());

        // RX overflow
        for (int unsigned i = 0; i < DEPTH + 1; i++) host_push(16'hC000 + 16'(i));
        @(negedge CLK);
        check("rx_ready_full", {15'b0, HOST_RX_READY}, 16'd0);
        read_reg("rx_ovf_status", A_STAT, exp_status());
        for (int unsigned i = 0; i < DEPTH; i++) data_read("rx_drain", 1, 1'b0, 16'h0);
        ctrl_write(16'h0004);
        read_reg("rx_ovf_clr", A_STAT, exp_status());

        // Simultaneous push and pop at level 3
        host_push(16'hA001);
        host_push(16'hA002);
        host_push(16'hA003);
        data_read("rd_sim", 1, 1'b1, 16'hA004);
        read_reg("lvl_sim", A_LVL, 16'h0003);
        for (int unsigned i = 0; i < 3; i++) data_read("rd_order", 1, 1'b0, 16'h0);
        read_reg("lvl_sim_empty", A_LVL, exp_level());

`ifdef BUS_MAILBOX_WATERMARK_EN
        ctrl_write(16'h0401);
        for (int unsigned i = 0; i < 3; i++) begin
            host_push(16'hB000 + 16'(i));
            tick();
            check("wm_irq_low", {15'b0, IRQ}, 16'd0);
        end
        host_push(16'hB003);
        tick();
        check("wm_irq_high", {15'b0, IRQ}, 16'd1);
        for (int unsigned i = 0; i < 4; i++) data_read("wm_drain", 1, 1'b0, 16'h0);
        cpu_write(A_CTRL, 16'h0000, 1'b0, 1'b0, 2);
`endif

        // Reset mid-read, with a write strobe held low across release
        host_push(16'hDEAD);
        ctrl_write(16'h0001);
        ADDR = A_DATA;
        RDN  = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        RDN  = 1'b1;
        DIN  = 16'h7777;
        WRN0 = 1'b0;
        tick();
        RESET = 1'b0;
        rx_q.delete();
        tx_q.delete();
        m_rx_ovf = 1'b0;
        m_rx_unf = 1'b0;
        m_tx_ovf = 1'b0;
        tick();
        tick();
        check("rst_no_write", {15'b0, HOST_TX_VALID}, 16'd0);
        check("rst_tx_data", HOST_TX_DATA, 16'h0000);
        WRN0 = 1'b1;
        tick();
        check("rst2_irq", {15'b0, IRQ}, 16'd0);
        check("rst2_rx_ready", {15'b0, HOST_RX_READY}, 16'd1);
        read_reg("rst2_status", A_STAT, 16'h0005);
        read_reg("rst2_ctrl", A_CTRL, 16'h0000);
        read_reg("rst2_level", A_LVL, 16'h0000);
        host_push(16'h0BEE);
        read_reg("rst2_lvl1", A_LVL, exp_level());
        data_read("rst2_data", 1, 1'b0, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
